arcade_input_hub: RTL

- Parametrised input front-end for arcade cores.
- Merges PS/2 keyboard events and two HPS joysticks into per-player, active-high button vectors.
- Adds coin-pulse shaping, per-button autofire, DIP-bank loading and game-mode (mod) latching from the ioctl stream.
- Sits between hps_io and the per-game input-byte assembly, so each core stops hand-rolling key decode, DIP and mod logic.

---
 rtl/arcade_input_hub.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_hub.sv
// arcade_input_hub: merges PS/2 keys and two joysticks into per-player button
// vectors. It adds coin-pulse shaping, per-button autofire, DIP-bank loading
// and mod latching from the ioctl download stream.
module arcade_input_hub #(
  parameter int NUM_DIP_BANKS     = 8,
  parameter int NUM_MODS          = 4,
  parameter int COIN_PULSE_CYCLES = 1200000,
  parameter int AUTOFIRE_DIV      = 600000
) (
  input  logic                       clk_sys_i,
  input  logic                       reset_i,
  input  logic [10:0]                ps2_key_i,
  input  logic [15:0]                joy_0_i,
  input  logic [15:0]                joy_1_i,
  input  logic                       ioctl_wr_i,
  input  logic [7:0]                 ioctl_index_i,
  input  logic [24:0]                ioctl_addr_i,
  input  logic [7:0]                 ioctl_dout_i,
  input  logic [3:0]                 autofire_en_i,
  output logic [15:0]                p1_btn_o,
  output logic [15:0]                p2_btn_o,
  output logic [8*NUM_DIP_BANKS-1:0] dip_flat_o,
  output logic [7:0]                 mod_id_o,
  output logic [NUM_MODS-1:0]        mod_onehot_o
);

  localparam int CW  = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;
  localparam int AFW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam int SH  = $clog2(NUM_DIP_BANKS);
  localparam int BW  = (NUM_DIP_BANKS > 1) ? SH : 1;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_HOLD  = 2'd2
  } coin_state_e;

  // Keyboard state: one register per decoded function, last event wins.
  logic        old_toggle_q, old_toggle_d;
  logic [10:0] key_q [2];
  logic [10:0] key_d [2];
  logic [10:0] raw_s [2];

  coin_state_e    coin_state_q [2];
  coin_state_e    coin_state_d [2];
  logic [CW-1:0]  coin_cnt_q [2];
  logic [CW-1:0]  coin_cnt_d [2];
  logic [1:0]     coin_out_s;

  logic [3:0]     af_phase_q [2];
  logic [3:0]     af_phase_d [2];
  logic [AFW-1:0] af_cnt_q [2][4];
  logic [AFW-1:0] af_cnt_d [2][4];
  logic [3:0]     fire_out_s [2];

  logic [15:0]    btn_q [2];
  logic [15:0]    btn_d [2];

  // Configuration is not reset: it must survive the reset that covers ROM download.
  logic [7:0]          dip_q [NUM_DIP_BANKS] = '{default: 8'd0};
  logic [7:0]          mod_id_q = 8'd0;
  logic [NUM_MODS-1:0] mod_onehot_q = NUM_MODS'(1);
  logic [NUM_MODS-1:0] mod_onehot_d;
  logic                dip_we_s;
  logic                mod_we_s;
  logic [BW-1:0]       bank_s;

  logic unused_inputs;
  assign unused_inputs = ^{ps2_key_i[8], joy_0_i[15:11], joy_1_i[15:11]};

  // Decode a PS/2 event (toggle edge) into the per-player key registers.
  always_comb begin
    old_toggle_d = old_toggle_q;
    key_d[0]     = key_q[0];
    key_d[1]     = key_q[1];
    if (ps2_key_i[10] != old_toggle_q) begin
      old_toggle_d = ps2_key_i[10];
      case (ps2_key_i[7:0])
        8'h75:        key_d[0][3]  = ps2_key_i[9];
        8'h72:        key_d[0][2]  = ps2_key_i[9];
        8'h6B:        key_d[0][1]  = ps2_key_i[9];
        8'h74:        key_d[0][0]  = ps2_key_i[9];
        8'h14:        key_d[0][4]  = ps2_key_i[9];
        8'h11:        key_d[0][5]  = ps2_key_i[9];
        8'h29:        key_d[0][6]  = ps2_key_i[9];
        8'h12:        key_d[0][7]  = ps2_key_i[9];
        8'h05, 8'h16: key_d[0][8]  = ps2_key_i[9];
        8'h06, 8'h1E: key_d[0][9]  = ps2_key_i[9];
        8'h2E:        key_d[0][10] = ps2_key_i[9];
        8'h2D:        key_d[1][3]  = ps2_key_i[9];
        8'h2B:        key_d[1][2]  = ps2_key_i[9];
        8'h23:        key_d[1][1]  = ps2_key_i[9];
        8'h34:        key_d[1][0]  = ps2_key_i[9];
        8'h36:        key_d[1][10] = ps2_key_i[9];
        default:      key_d[0]     = key_q[0];
      endcase
    end else begin
      old_toggle_d = old_toggle_q;
    end
  end

  assign raw_s[0] = key_q[0] | joy_0_i[10:0];
  assign raw_s[1] = key_q[1] | joy_1_i[10:0];

  // Coin shaper: one fixed-length pulse per press, then wait for release.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      coin_state_d[p] = coin_state_q[p];
      coin_cnt_d[p]   = coin_cnt_q[p];
      case (coin_state_q[p])
        COIN_IDLE: begin
          if (raw_s[p][10]) begin
            coin_state_d[p] = COIN_PULSE;
            coin_cnt_d[p]   = CW'(COIN_PULSE_CYCLES - 1);
          end else begin
            coin_state_d[p] = COIN_IDLE;
          end
        end
        COIN_PULSE: begin
          if (coin_cnt_q[p] == {CW{1'b0}}) begin
            coin_state_d[p] = raw_s[p][10] ? COIN_HOLD : COIN_IDLE;
          end else begin
            coin_cnt_d[p] = coin_cnt_q[p] - CW'(1);
          end
        end
        COIN_HOLD: begin
          if (!raw_s[p][10]) begin
            coin_state_d[p] = COIN_IDLE;
          end else begin
            coin_state_d[p] = COIN_HOLD;
          end
        end
        default: coin_state_d[p] = COIN_IDLE;
      endcase
      // Output follows the next state so a joystick coin shows after one cycle.
      coin_out_s[p] = (coin_state_d[p] == COIN_PULSE);
    end
  end

  // Autofire: phase starts high on press and flips every AUTOFIRE_DIV cycles.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      af_phase_d[p] = af_phase_q[p];
      fire_out_s[p] = 4'b0000;
      for (int b = 0; b < 4; b++) begin
        af_cnt_d[p][b] = af_cnt_q[p][b];
        if (autofire_en_i[b] && raw_s[p][4+b]) begin
          fire_out_s[p][b] = af_phase_q[p][b];
          if (af_cnt_q[p][b] == {AFW{1'b0}}) begin
            af_cnt_d[p][b]   = AFW'(AUTOFIRE_DIV - 1);
            af_phase_d[p][b] = ~af_phase_q[p][b];
          end else begin
            af_cnt_d[p][b] = af_cnt_q[p][b] - AFW'(1);
          end
        end else begin
          fire_out_s[p][b] = raw_s[p][4+b];
          af_cnt_d[p][b]   = AFW'(AUTOFIRE_DIV - 1);
          af_phase_d[p][b] = 1'b1;
        end
      end
    end
  end

  // Assemble the next button vectors from the merged and shaped inputs.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      btn_d[p] = {5'd0, coin_out_s[p], raw_s[p][9:8], fire_out_s[p], raw_s[p][3:0]};
    end
  end

  // Input-path state; release of reset must not see a spurious key event.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      old_toggle_q <= ps2_key_i[10];
      for (int p = 0; p < 2; p++) begin
        key_q[p]        <= 11'd0;
        coin_state_q[p] <= COIN_IDLE;
        coin_cnt_q[p]   <= {CW{1'b0}};
        af_phase_q[p]   <= 4'b1111;
        btn_q[p]        <= 16'd0;
        for (int b = 0; b < 4; b++) begin
          af_cnt_q[p][b] <= AFW'(AUTOFIRE_DIV - 1);
        end
      end
    end else begin
      old_toggle_q <= old_toggle_d;
      for (int p = 0; p < 2; p++) begin
        key_q[p]        <= key_d[p];
        coin_state_q[p] <= coin_state_d[p];
        coin_cnt_q[p]   <= coin_cnt_d[p];
        af_phase_q[p]   <= af_phase_d[p];
        btn_q[p]        <= btn_d[p];
        for (int b = 0; b < 4; b++) begin
          af_cnt_q[p][b] <= af_cnt_d[p][b];
        end
      end
    end
  end

  assign dip_we_s = ioctl_wr_i && (ioctl_index_i == 8'd254) &&
                    ((ioctl_addr_i >> SH) == 25'd0);
  assign mod_we_s = ioctl_wr_i && (ioctl_index_i == 8'd1);
  assign bank_s   = ioctl_addr_i[BW-1:0];

  // Decode the latched mod id into a one-hot select; out-of-range ids give zero.
  always_comb begin
    mod_onehot_d = {NUM_MODS{1'b0}};
    for (int i = 0; i < NUM_MODS; i++) begin
      mod_onehot_d[i] = (mod_id_q == 8'(i));
    end
  end

  // Download-driven configuration, deliberately written even while reset is high.
  always_ff @(posedge clk_sys_i) begin
    for (int k = 0; k < NUM_DIP_BANKS; k++) begin
      if (dip_we_s && (bank_s == BW'(k))) begin
        dip_q[k] <= ioctl_dout_i;
      end
    end
    if (mod_we_s) begin
      mod_id_q <= ioctl_dout_i;
    end
    mod_onehot_q <= mod_onehot_d;
  end

  // Flatten the DIP banks, byte k at [8k+7:8k].
  always_comb begin
    dip_flat_o = {(8*NUM_DIP_BANKS){1'b0}};
    for (int k = 0; k < NUM_DIP_BANKS; k++) begin
      dip_flat_o[8*k +: 8] = dip_q[k];
    end
  end

  assign p1_btn_o     = btn_q[0];
  assign p2_btn_o     = btn_q[1];
  assign mod_id_o     = mod_id_q;
  assign mod_onehot_o = mod_onehot_q;

endmodule
